axi_rd_arbiter: RTL and testbench

Two-requester read-channel arbiter. It shares the core's single AXI read port (AR/R) between the instruction fetch unit (IFU) and the load/store unit (LSU).
Each requester sees a private single-beat AR/R interface. The arbiter serialises their reads onto the shared port, one outstanding transaction at a time, with a registered address and a registered response buffer.
The write channels (AW/W/B) bypass this block. Load ordering against stores is enforced through lsu_st_pending.

---
 rtl/axi_rd_arbiter_if.sv | 32 +++
 rtl/axi_rd_arbiter.sv | 157 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_if.sv
//==============================================================================
// Module      : axi_rd_arbiter_if
// Description : Single-beat AXI read channel bundle (AR + R). The master
//               modport issues addresses and accepts data; the slave modport
//               accepts addresses and returns data.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] AR_ADDR;
    logic              AR_VALID;
    logic              AR_READY;
    logic [DATA_W-1:0] R_DATA;
    logic              R_VALID;
    logic              R_READY;

    modport master (
        output AR_ADDR, AR_VALID, R_READY,
        input  AR_READY, R_DATA, R_VALID
    );

    modport slave (
        input  AR_ADDR, AR_VALID, R_READY,
        output AR_READY, R_DATA, R_VALID
    );
endinterface

`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
//==============================================================================
// Module      : axi_rd_arbiter
// Description : Two-requester (IFU, LSU) read-channel arbiter onto one shared
//               AXI read port. One outstanding transaction, registered address
//               and registered response buffer. LSU reads are held off while
//               lsu_st_pending is high (sampled only when idle).
//               Optional macro AXI_ARB_RR_EN selects round-robin priority;
//               without it the LSU wins every tie.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi_rd_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    axi_rd_arbiter_if.slave         ifu,
    axi_rd_arbiter_if.slave         lsu,
    axi_rd_arbiter_if.master        axi,
    input  logic                    lsu_st_pending,
    output logic                    arb_busy,
    output logic                    arb_owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Owner encoding: 0 = IFU, 1 = LSU
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                owner_q, owner_d;

    logic                ifu_req;
    logic                lsu_req;
    logic                gnt_ifu;
    logic                gnt_lsu;
    logic                in_idle;
    logic                in_resp;
    logic                owner_r_ready;

`ifdef AXI_ARB_RR_EN
    logic                last_gnt_q, last_gnt_d;
`endif

    assign in_idle = (state_q == S_IDLE);
    assign in_resp = (state_q == S_RESP);

    // Eligibility and priority: a tie goes to LSU, or alternates when round-robin
    always_comb begin
        ifu_req = ifu.AR_VALID;
        lsu_req = lsu.AR_VALID & ~lsu_st_pending;
`ifdef AXI_ARB_RR_EN
        gnt_lsu = lsu_req & (~ifu_req | (last_gnt_q == OWN_IFU));
`else
        gnt_lsu = lsu_req;
`endif
        gnt_ifu = ifu_req & ~gnt_lsu;
    end

    assign owner_r_ready = (owner_q == OWN_LSU) ? lsu.R_READY : ifu.R_READY;

    // Next-state, address latch and response buffer capture
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rdata_d = rdata_q;
        owner_d = owner_q;
`ifdef AXI_ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt_ifu | gnt_lsu) begin
                    addr_d  = gnt_lsu ? lsu.AR_ADDR : ifu.AR_ADDR;
                    owner_d = gnt_lsu ? OWN_LSU : OWN_IFU;
`ifdef AXI_ARB_RR_EN
                    last_gnt_d = gnt_lsu ? OWN_LSU : OWN_IFU;
`endif
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (axi.AR_READY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (axi.R_VALID) begin
                    rdata_d = axi.R_DATA;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (owner_r_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, address, buffer and owner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            owner_q <= OWN_IFU;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            owner_q <= owner_d;
        end
    end

`ifdef AXI_ARB_RR_EN
    // Round-robin history; starts at LSU so the first tie favours IFU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q <= OWN_LSU;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

    // Requester AR_READY is qualified by rst_n so it stays low throughout
    // reset even though IDLE grants combinationally from live requests.
    assign ifu.AR_READY = rst_n & in_idle & gnt_ifu;
    assign lsu.AR_READY = rst_n & in_idle & gnt_lsu;

    assign ifu.R_VALID  = in_resp & (owner_q == OWN_IFU);
    assign lsu.R_VALID  = in_resp & (owner_q == OWN_LSU);
    assign ifu.R_DATA   = ifu.R_VALID ? rdata_q : '0;
    assign lsu.R_DATA   = lsu.R_VALID ? rdata_q : '0;

    assign axi.AR_VALID = (state_q == S_ADDR);
    assign axi.AR_ADDR  = addr_q;
    assign axi.R_READY  = (state_q == S_DATA);

    assign arb_busy     = ~in_idle;
    assign arb_owner    = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
//==============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Directed self-checking bench for axi_rd_arbiter. Expectations
//               for the tie-break follow AXI_ARB_RR_EN when it is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axi_rd_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic lsu_st_pending;
    logic arb_busy;
    logic arb_owner;

    int n_run  = 0;
    int n_fail = 0;

    axi_rd_arbiter_if #(.ADDR_W(64), .DATA_W(64)) ifu_if ();
    axi_rd_arbiter_if #(.ADDR_W(64), .DATA_W(64)) lsu_if ();
    axi_rd_arbiter_if #(.ADDR_W(64), .DATA_W(64)) axi_if ();

    axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu            (ifu_if),
        .lsu            (lsu_if),
        .axi            (axi_if),
        .lsu_st_pending (lsu_st_pending),
        .arb_busy       (arb_busy),
        .arb_owner      (arb_owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the grant edge (state ADDR) with axi AR_READY=1
    // and both requester R_READY=1; returns one step after the IDLE edge.
    task automatic serve(input logic exp_owner, input logic [63:0] exp_addr,
                         input logic [63:0] data);
        #1;
        chk("addr_ar_valid", axi_if.AR_VALID, 1);
        chk("addr_ar_addr",  axi_if.AR_ADDR,  exp_addr);
        chk("addr_owner",    arb_owner,       exp_owner);
        chk("addr_busy",     arb_busy,        1);
        axi_if.R_DATA  = data;
        axi_if.R_VALID = 1'b1;
        cyc();
        chk("data_r_ready",  axi_if.R_READY,  1);
        cyc();
        axi_if.R_VALID = 1'b0;
        axi_if.R_DATA  = '0;
        #1;
        chk("resp_ifu_rv",   ifu_if.R_VALID,  !exp_owner);
        chk("resp_lsu_rv",   lsu_if.R_VALID,  exp_owner);
        chk("resp_own_data", exp_owner ? lsu_if.R_DATA : ifu_if.R_DATA, data);
        chk("resp_oth_data", exp_owner ? ifu_if.R_DATA : lsu_if.R_DATA, 64'd0);
        cyc();
        chk("idle_ifu_rv",   ifu_if.R_VALID,  0);
        chk("idle_lsu_rv",   lsu_if.R_VALID,  0);
    endtask

    initial begin
        rst_n           = 1'b0;
        lsu_st_pending  = 1'b0;
        ifu_if.AR_ADDR  = 64'h0;
        ifu_if.AR_VALID = 1'b1;   // live request during reset must not be accepted
        ifu_if.R_READY  = 1'b1;
        lsu_if.AR_ADDR  = 64'h0;
        lsu_if.AR_VALID = 1'b0;
        lsu_if.R_READY  = 1'b1;
        axi_if.AR_READY = 1'b0;
        axi_if.R_DATA   = 64'h0;
        axi_if.R_VALID  = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ifu_ar_ready", ifu_if.AR_READY, 0);
        chk("rst_lsu_ar_ready", lsu_if.AR_READY, 0);
        chk("rst_axi_ar_valid", axi_if.AR_VALID, 0);
        chk("rst_axi_ar_addr",  axi_if.AR_ADDR,  64'd0);
        chk("rst_axi_r_ready",  axi_if.R_READY,  0);
        chk("rst_ifu_r_valid",  ifu_if.R_VALID,  0);
        chk("rst_lsu_r_valid",  lsu_if.R_VALID,  0);
        chk("rst_ifu_r_data",   ifu_if.R_DATA,   64'd0);
        chk("rst_lsu_r_data",   lsu_if.R_DATA,   64'd0);
        chk("rst_busy",         arb_busy,        0);
        chk("rst_owner",        arb_owner,       0);
        ifu_if.AR_VALID = 1'b0;
        #2 rst_n = 1'b1;
        axi_if.AR_READY = 1'b1;

        // ---- simultaneous requests ----
        ifu_if.AR_ADDR  = 64'h100;
        lsu_if.AR_ADDR  = 64'h200;
        ifu_if.AR_VALID = 1'b1;
        lsu_if.AR_VALID = 1'b1;
`ifdef AXI_ARB_RR_EN
        // Both held valid: alternation starting with IFU
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ifu_ar_ready", ifu_if.AR_READY, (i % 2) == 0);
            chk("rr_lsu_ar_ready", lsu_if.AR_READY, (i % 2) == 1);
            cyc();
            serve((i % 2) == 1, ((i % 2) == 1) ? 64'h200 : 64'h100,
                  64'hA5A5_0000_0000_0000 + 64'(i));
        end
        ifu_if.AR_VALID = 1'b0;
        lsu_if.AR_VALID = 1'b0;
`else
        #1;
        chk("fp_lsu_ar_ready", lsu_if.AR_READY, 1);
        chk("fp_ifu_ar_ready", ifu_if.AR_READY, 0);
        cyc();
        lsu_if.AR_VALID = 1'b0;
        serve(1'b1, 64'h200, 64'hCAFE_0000_0000_0200);
        #1;
        chk("fp_ifu_next_ready", ifu_if.AR_READY, 1);
        chk("fp_gap_busy",       arb_busy,        0);
        cyc();
        ifu_if.AR_VALID = 1'b0;
        serve(1'b0, 64'h100, 64'hCAFE_0000_0000_0100);
`endif

        // ---- IFU-only read, zero-wait slave ----
        ifu_if.AR_ADDR  = 64'h8000_0000;
        ifu_if.AR_VALID = 1'b1;
        #1;
        chk("ifu_only_ar_ready", ifu_if.AR_READY, 1);
        chk("ifu_only_lsu_rdy",  lsu_if.AR_READY, 0);
        cyc();
        ifu_if.AR_VALID = 1'b0;
        serve(1'b0, 64'h8000_0000, 64'h1122_3344_5566_7788);
        chk("ifu_only_owner", arb_owner, 0);

        // ---- lsu_st_pending blocks LSU, then releases it ----
        lsu_st_pending  = 1'b1;
        ifu_if.AR_ADDR  = 64'h300;
        lsu_if.AR_ADDR  = 64'h400;
        ifu_if.AR_VALID = 1'b1;
        lsu_if.AR_VALID = 1'b1;
        #1;
        chk("stp_ifu_ar_ready", ifu_if.AR_READY, 1);
        chk("stp_lsu_ar_ready", lsu_if.AR_READY, 0);
        cyc();
        ifu_if.AR_VALID = 1'b0;
        lsu_st_pending  = 1'b0;
        serve(1'b0, 64'h300, 64'h0000_3333_0000_3333);
        #1;
        chk("stp_lsu_next_ready", lsu_if.AR_READY, 1);
        cyc();
        lsu_if.AR_VALID = 1'b0;
        lsu_st_pending  = 1'b1;   // raised mid-transaction: must not abort
        serve(1'b1, 64'h400, 64'h0000_4444_0000_4444);
        lsu_st_pending  = 1'b0;

        // ---- slave and requester backpressure ----
        axi_if.AR_READY = 1'b0;
        ifu_if.AR_ADDR  = 64'hA0;
        ifu_if.AR_VALID = 1'b1;
        cyc();
        ifu_if.AR_VALID = 1'b0;
        ifu_if.AR_ADDR  = 64'hFFFF;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ar_valid_hold", axi_if.AR_VALID, 1);
            chk("bp_ar_addr_hold",  axi_if.AR_ADDR,  64'hA0);
            cyc();
        end
        axi_if.AR_READY = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("bp_data_r_ready", axi_if.R_READY, 1);
            chk("bp_data_no_rv",   ifu_if.R_VALID, 0);
            cyc();
        end
        axi_if.R_DATA  = 64'hDEAD_BEEF_0BAD_F00D;
        axi_if.R_VALID = 1'b1;
        ifu_if.R_READY = 1'b0;
        cyc();
        axi_if.R_VALID = 1'b0;
        axi_if.R_DATA  = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_resp_rv",   ifu_if.R_VALID, 1);
            chk("bp_resp_data", ifu_if.R_DATA,  64'hDEAD_BEEF_0BAD_F00D);
            cyc();
        end
        ifu_if.R_READY = 1'b1;
        #1;
        chk("bp_resp_rv_last", ifu_if.R_VALID, 1);
        cyc();
        chk("bp_done_busy", arb_busy,       0);
        chk("bp_done_rv",   ifu_if.R_VALID, 0);
        cyc();
        chk("bp_single_xact", arb_busy, 0);

        // ---- reset in DATA ----
        ifu_if.AR_ADDR  = 64'h500;
        ifu_if.AR_VALID = 1'b1;
        cyc();
        ifu_if.AR_VALID = 1'b0;
        cyc();
        chk("rd_in_data", axi_if.R_READY, 1);
        lsu_if.AR_ADDR  = 64'h600;
        lsu_if.AR_VALID = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rd_axi_r_ready",  axi_if.R_READY,  0);
        chk("rd_axi_ar_valid", axi_if.AR_VALID, 0);
        chk("rd_lsu_ar_ready", lsu_if.AR_READY, 0);
        chk("rd_ifu_ar_ready", ifu_if.AR_READY, 0);
        chk("rd_ifu_r_valid",  ifu_if.R_VALID,  0);
        chk("rd_busy",         arb_busy,        0);
        cyc();
        chk("rd_hold_lsu_rdy", lsu_if.AR_READY, 0);
        #2 rst_n = 1'b1;
        #1;
        chk("rd_post_busy",      arb_busy,        0);
        chk("rd_post_owner",     arb_owner,       0);
        chk("rd_post_lsu_ready", lsu_if.AR_READY, 1);
        cyc();
        lsu_if.AR_VALID = 1'b0;
        serve(1'b1, 64'h600, 64'h0600_0600_0600_0600);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
